except_arbiter: RTL
===================

EXCEPT_ARBITER -- requirements
Module: except_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8: number of synchronous exception sources; legal range 1..16.
REQ-002 SHALL have parameter NUM_HW_INT, default 6: number of hardware interrupt lines.
REQ-003 SHALL have parameter VEC_ADDR, default 32'hBFC00380: common exception entry address.
REQ-004 SHALL have one clock and an asynchronous active-low reset, named clk and resetn.
REQ-005 SHALL have the following ports: clk  in  1  rising-edge clock.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 ext_int  in  NUM_HW_INT  raw hardware interrupt lines, asynchronous to clk.
REQ-008 cp0_status  in  32  Status; uses IM=[15:8], EXL=[1], IE=[0].
REQ-009 cp0_cause  in  32  Cause; uses IP[9:8] (software interrupts).
REQ-010 cp0_epc  in  32  EPC, the ERET target.
REQ-011 src_valid  in  NUM_SRC  per-source exception request from the M stage.
REQ-012 src_code  in  5*NUM_SRC  ExcCode of source i, held at bits [5i+4:5i].
REQ-013 is_eretM  in  1  ERET in the M stage.
REQ-014 inst_validM  in  1  M stage holds a real instruction (not a bubble).
REQ-015 mem_busy  in  1  memory access outstanding; commit is not allowed while high.
REQ-016 redirect_ack  in  1  fetch has accepted the new PC.
REQ-017 flush  out  1  one-cycle pulse that flushes F, D, E and M.
REQ-018 except_valid  out  1  one-cycle pulse; CP0 writes EPC, Cause and EXL.
REQ-019 except_code  out  5  committed ExcCode (5'h00 for interrupt, 5'h0e marker for ERET).
REQ-020 except_pc  out  32  redirect target.
REQ-021 busy  out  1  high outside IDLE; stalls the pipeline.

Function
REQ-022 SHALL pass ext_int through a 2-flop synchroniser; only the synchronised value, int_sync, is used.
REQ-023 SHALL compute int_req = |(cp0_status[15:8] & {int_sync, cp0_cause[9:8]}) & ~cp0_status[1] & cp0_status[0], zero-extended when NUM_HW_INT<6.
REQ-024 SHALL apply fixed priority: int_req (qualified by inst_validM) > src_valid[0] > ... > src_valid[NUM_SRC-1] > is_eretM.
REQ-025 SHALL treat a request as pending only when inst_validM=1.
REQ-026 SHALL use FSM states IDLE, WAIT, COMMIT, REDIR.
REQ-027 IDLE: on a pending request, latch the winning code and target; go to WAIT if mem_busy=1, otherwise go to COMMIT.
REQ-028 WAIT: hold the latched winner and ignore new requests; go to COMMIT in the first cycle with mem_busy=0.
REQ-029 COMMIT: assert flush and except_valid for exactly one cycle; go to REDIR.
REQ-030 REDIR: hold except_pc and busy; go to IDLE in the cycle redirect_ack=1; the earliest new arbitration is the next cycle.
REQ-031 SHALL set except_pc = cp0_epc sampled at latch time for ERET, and VEC_ADDR for every other winner.
REQ-032 Latency: request in IDLE with mem_busy=0 leads to the flush pulse on the next edge, i.e. 1 cycle.
REQ-033 SHALL set busy=1 in WAIT, COMMIT and REDIR, and busy=0 in IDLE.
REQ-034 A request that appears while the FSM is not in IDLE SHALL be dropped; the source re-asserts after refetch.
REQ-035 Changes to cp0_status during WAIT SHALL NOT alter the latched winner.
REQ-036 SHALL keep except_code and except_pc stable from latch until the return to IDLE.

Reset
REQ-037 resetn=0 SHALL asynchronously force the state to IDLE, clear the synchroniser, and drive flush=0, except_valid=0, busy=0, except_code=0, except_pc=0.
REQ-038 resetn asserted in any state SHALL abort the operation with no flush pulse; the first arbitration is the cycle after resetn rises.

Verification
REQ-039 Test: Status=32'h0000FF01, ext_int[0] held high, inst_validM=1 -> after sync plus 1 cycle: flush=1, code=5'h00, except_pc=32'hBFC00380.
REQ-040 Test: src_valid=8'b0000_0110 with codes 5'h04 and 5'h05 -> code=5'h04; src1 wins.
REQ-041 Test: src_valid[3]=1 (code 5'h08), mem_busy=1 for 3 cycles -> busy=1 throughout; flush in the first cycle after mem_busy falls.
REQ-042 Test: is_eretM=1, cp0_epc=32'hBFC01234, no other request -> except_pc=32'hBFC01234, code=5'h0e.
REQ-043 Test: Status EXL=1 with interrupt lines active -> no interrupt; a concurrent src_valid[2] is committed instead.
REQ-044 Test: resetn pulsed low while in WAIT -> outputs zero immediately; no flush pulse afterward; a request after reset release is handled normally.

Source files
------------

// File: rtl/except_arbiter.sv
// Exception arbiter: picks the highest-priority M-stage exception, interrupt or ERET,
// waits for outstanding memory traffic, then pulses flush and holds the redirect PC.
module except_arbiter #(
  parameter int          NUM_SRC    = 8,
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] VEC_ADDR   = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_HW_INT-1:0] ext_int,
  input  logic [31:0]           cp0_status,
  input  logic [31:0]           cp0_cause,
  input  logic [31:0]           cp0_epc,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [5*NUM_SRC-1:0]  src_code,
  input  logic                  is_eretM,
  input  logic                  inst_validM,
  input  logic                  mem_busy,
  input  logic                  redirect_ack,
  output logic                  flush,
  output logic                  except_valid,
  output logic [4:0]            except_code,
  output logic [31:0]           except_pc,
  output logic                  busy
);

  localparam int         HW_USE    = (NUM_HW_INT < 6) ? NUM_HW_INT : 6;
  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ERET = 5'h0e;

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, REDIR} state_t;

  state_t                state, state_next;
  logic [NUM_HW_INT-1:0] int_meta, int_sync;
  logic [5:0]            hw_int;
  logic [7:0]            ip_all;
  logic                  int_req;
  logic                  req_any;
  logic                  latch_en;
  logic [4:0]            win_code, code_q;
  logic [31:0]           win_pc, pc_q;
  logic                  unused_bits;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      int_meta <= '0;
      int_sync <= '0;
    end else begin
      int_meta <= ext_int;
      int_sync <= int_meta;
    end
  end

  always_comb begin
    hw_int = '0;
    hw_int[HW_USE-1:0] = int_sync[HW_USE-1:0];
  end

  assign ip_all  = {hw_int, cp0_cause[9:8]};
  assign int_req = (|(cp0_status[15:8] & ip_all)) & ~cp0_status[1] & cp0_status[0];

  // Lowest-priority candidates are assigned first so later, higher-priority ones override.
  always_comb begin
    req_any  = 1'b0;
    win_code = CODE_INT;
    win_pc   = VEC_ADDR;
    if (inst_validM) begin
      if (is_eretM) begin
        req_any  = 1'b1;
        win_code = CODE_ERET;
        win_pc   = cp0_epc;
      end
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (src_valid[i]) begin
          req_any  = 1'b1;
          win_code = src_code[5*i +: 5];
          win_pc   = VEC_ADDR;
        end
      end
      if (int_req) begin
        req_any  = 1'b1;
        win_code = CODE_INT;
        win_pc   = VEC_ADDR;
      end
    end
  end

  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          latch_en   = 1'b1;
          state_next = mem_busy ? WAIT : COMMIT;
        end
      end
      WAIT:    if (!mem_busy) state_next = COMMIT;
      COMMIT:  state_next = REDIR;
      REDIR:   if (redirect_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      code_q <= '0;
      pc_q   <= '0;
    end else begin
      state <= state_next;
      if (latch_en) begin
        code_q <= win_code;
        pc_q   <= win_pc;
      end
    end
  end

  assign flush        = (state == COMMIT);
  assign except_valid = (state == COMMIT);
  assign busy         = (state != IDLE);
  assign except_code  = code_q;
  assign except_pc    = pc_q;

  assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:10],
                         cp0_cause[7:0], int_sync};

endmodule
